// File: rtl/squ_cond_gate.sv
// Square-input conditioning gate for time_measure: sync, glitch filter, edge-ordered step outputs.
// Optional build macro SQU_GLITCH_CNT_EN adds per-channel aborted-glitch counters.
module squ_cond_gate #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        squ_in0,
  input  logic        squ_in1,
  output logic        squ_r0,
  output logic        squ_r1,
  output logic        filt0,
  output logic        filt1,
  output logic        busy,
  output logic        done,
  output logic        timeout
`ifdef SQU_GLITCH_CNT_EN
  ,
  output logic [15:0] glitch_cnt0,
  output logic [15:0] glitch_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, HOLD} state_t;

  localparam logic [7:0]  FC_LAST = 8'(FILT_LEN - 1);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_rise;
`ifdef SQU_GLITCH_CNT_EN
  logic [15:0] w_gcnt [2];
`endif

  assign w_raw = {squ_in1, squ_in0};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [7:0]             r_fc;
    logic                   r_lvl;
    logic                   r_lvl_d;
    logic                   w_sn;

    assign w_sn = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= '0;
        r_fc    <= '0;
        r_lvl   <= 1'b0;
        r_lvl_d <= 1'b0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
        r_lvl_d <= r_lvl;
        if (w_sn == r_lvl) begin
          r_fc <= '0;
        end else if (r_fc == FC_LAST) begin
          r_lvl <= w_sn;
          r_fc  <= '0;
        end else begin
          r_fc <= r_fc + 8'd1;
        end
      end
    end

    assign w_filt[g] = r_lvl;
    assign w_rise[g] = r_lvl & ~r_lvl_d;

`ifdef SQU_GLITCH_CNT_EN
    logic [15:0] r_gcnt;
    // A run is aborted when the sample falls back to the filtered level mid-count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_gcnt <= '0;
      end else if (arm) begin
        r_gcnt <= '0;
      end else if ((w_sn == r_lvl) && (r_fc != '0) && (r_gcnt != '1)) begin
        r_gcnt <= r_gcnt + 16'd1;
      end
    end
    assign w_gcnt[g] = r_gcnt;
`endif
  end

  state_t      r_state, w_state;
  logic        r_sq0, w_sq0;
  logic        r_sq1, w_sq1;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_to, w_to;
  logic [31:0] r_timer, w_timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sq0   <= 1'b0;
      r_sq1   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state;
      r_sq0   <= w_sq0;
      r_sq1   <= w_sq1;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_to    <= w_to;
      r_timer <= w_timer;
    end
  end

  // Priority inside a measurement: arm restart, then timeout abort, then edge events.
  always_comb begin
    w_state = r_state;
    w_sq0   = r_sq0;
    w_sq1   = r_sq1;
    w_done  = 1'b0;
    w_to    = 1'b0;
    w_timer = r_timer;
    unique case (r_state)
      IDLE: begin
        w_sq0 = 1'b0;
        w_sq1 = 1'b0;
        if (arm) begin
          w_state = WAIT0;
          w_timer = '0;
        end
      end
      WAIT0, WAIT1: begin
        w_timer = r_timer + 32'd1;
        if (arm) begin
          w_state = WAIT0;
          w_sq0   = 1'b0;
          w_sq1   = 1'b0;
          w_timer = '0;
        end else if (TO_EN && (r_timer == TO_LAST)) begin
          w_state = IDLE;
          w_sq0   = 1'b0;
          w_sq1   = 1'b0;
          w_to    = 1'b1;
        end else if ((r_state == WAIT0) && w_rise[0]) begin
          w_state = WAIT1;
          w_sq0   = 1'b1;
        end else if ((r_state == WAIT1) && w_rise[1]) begin
          w_state = HOLD;
          w_sq1   = 1'b1;
          w_done  = 1'b1;
        end
      end
      HOLD: begin
        if (arm) begin
          w_state = WAIT0;
          w_sq0   = 1'b0;
          w_sq1   = 1'b0;
          w_timer = '0;
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state == WAIT0) || (w_state == WAIT1);
  end

  assign squ_r0  = r_sq0;
  assign squ_r1  = r_sq1;
  assign filt0   = w_filt[0];
  assign filt1   = w_filt[1];
  assign busy    = r_busy;
  assign done    = r_done;
  assign timeout = r_to;
`ifdef SQU_GLITCH_CNT_EN
  assign glitch_cnt0 = w_gcnt[0];
  assign glitch_cnt1 = w_gcnt[1];
`endif

endmodule

// File: tb/tb_squ_cond_gate.sv
// Directed self-checking bench for squ_cond_gate (timeout DUT at 1000 cycles, second DUT with timeout off).
module tb_squ_cond_gate;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic arm2 = 1'b0;
  logic squ_in0 = 1'b0;
  logic squ_in1 = 1'b0;
  logic squ_r0, squ_r1, filt0, filt1, busy, done, timeout;
  logic squ_r0_2, squ_r1_2, filt0_2, filt1_2, busy_2, done_2, timeout_2;
`ifdef SQU_GLITCH_CNT_EN
  logic [15:0] glitch_cnt0, glitch_cnt1, glitch_cnt0_2, glitch_cnt1_2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_to2 = 0;

  always #5 clk = ~clk;

  squ_cond_gate #(.SYNC_STAGES(2), .FILT_LEN(4), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst), .arm(arm), .squ_in0(squ_in0), .squ_in1(squ_in1),
    .squ_r0(squ_r0), .squ_r1(squ_r1), .filt0(filt0), .filt1(filt1),
    .busy(busy), .done(done), .timeout(timeout)
`ifdef SQU_GLITCH_CNT_EN
    , .glitch_cnt0(glitch_cnt0), .glitch_cnt1(glitch_cnt1)
`endif
  );

  squ_cond_gate #(.SYNC_STAGES(2), .FILT_LEN(4), .TIMEOUT_CYC(0)) dut2 (
    .clk(clk), .rst(rst), .arm(arm2), .squ_in0(squ_in0), .squ_in1(squ_in1),
    .squ_r0(squ_r0_2), .squ_r1(squ_r1_2), .filt0(filt0_2), .filt1(filt1_2),
    .busy(busy_2), .done(done_2), .timeout(timeout_2)
`ifdef SQU_GLITCH_CNT_EN
    , .glitch_cnt0(glitch_cnt0_2), .glitch_cnt1(glitch_cnt1_2)
`endif
  );

  always @(posedge clk) if (timeout_2) n_to2++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return 16'({squ_r0, squ_r1, filt0, filt1, busy, done, timeout});
  endfunction

  initial begin
    // reset held with inputs toggling
    for (int i = 0; i < 10; i++) begin
      squ_in0 = i[0];
      squ_in1 = ~i[0];
      step(1);
    end
    check("reset_outputs", outs(), 16'h0);
    squ_in0 = 1'b0;
    squ_in1 = 1'b0;
    rst = 1'b0;
    step(20);
    check("idle_busy", 16'(busy), 16'h0);
    check("idle_outputs", outs(), 16'h0);

    // clean measurement, 150-cycle interval
    arm_pulse();
    check("m1_busy_after_arm", 16'(busy), 16'h1);
    step(49);
    squ_in0 = 1'b1;
    step(6);
    check("m1_filt0_lat6", 16'(filt0), 16'h1);
    check("m1_r0_lat6", 16'(squ_r0), 16'h0);
    step(1);
    check("m1_r0_lat7", 16'(squ_r0), 16'h1);
    check("m1_busy_wait1", 16'(busy), 16'h1);
    step(143);
    squ_in1 = 1'b1;
    step(6);
    check("m1_filt1_lat6", 16'(filt1), 16'h1);
    check("m1_r1_lat6", 16'(squ_r1), 16'h0);
    step(1);
    check("m1_r1_lat7", 16'(squ_r1), 16'h1);
    check("m1_done", 16'(done), 16'h1);
    check("m1_busy_hold", 16'(busy), 16'h0);
    step(1);
    check("m1_done_one_cycle", 16'(done), 16'h0);
    squ_in0 = 1'b0;
    squ_in1 = 1'b0;
    step(12);
    check("m1_hold_levels", 16'({squ_r0, squ_r1}), 16'h3);

    // re-arm from HOLD, ch1 first, glitches on ch0
    arm_pulse();
    check("m2_rearm_clear", 16'({squ_r0, squ_r1}), 16'h0);
    check("m2_busy", 16'(busy), 16'h1);
    squ_in1 = 1'b1;
    step(12);
    check("m2_filt1_early", 16'(filt1), 16'h1);
    check("m2_r1_ignored", 16'(squ_r1), 16'h0);
    repeat (2) begin
      squ_in0 = 1'b1;
      step(3);
      squ_in0 = 1'b0;
      step(6);
    end
    check("m2_glitch_filt0", 16'(filt0), 16'h0);
    check("m2_glitch_r0", 16'(squ_r0), 16'h0);
`ifdef SQU_GLITCH_CNT_EN
    check("m2_glitch_cnt0", glitch_cnt0, 16'd2);
`endif
    squ_in0 = 1'b1;
    step(4);
    squ_in0 = 1'b0;
    step(2);
    check("m2_pulse4_r0_early", 16'(squ_r0), 16'h0);
    step(1);
    check("m2_pulse4_r0", 16'(squ_r0), 16'h1);
    step(5);
    check("m2_r1_needs_new_edge", 16'(squ_r1), 16'h0);
    squ_in1 = 1'b0;
    step(10);
    squ_in1 = 1'b1;
    step(6);
    check("m2_r1_early", 16'(squ_r1), 16'h0);
    step(1);
    check("m2_r1", 16'(squ_r1), 16'h1);
    check("m2_done", 16'(done), 16'h1);

    // simultaneous ch0/ch1 edges
    squ_in0 = 1'b0;
    squ_in1 = 1'b0;
    step(10);
    arm_pulse();
    squ_in0 = 1'b1;
    squ_in1 = 1'b1;
    step(7);
    check("m3_simul_r", 16'({squ_r0, squ_r1}), 16'h2);
    step(20);
    check("m3_still_wait1", 16'({squ_r0, squ_r1, busy}), 16'h5);

    // arm in WAIT1 restarts timer; then timeout with no edges
    arm_pulse();
    check("m4_rearm_r0", 16'(squ_r0), 16'h0);
    check("m4_rearm_busy", 16'(busy), 16'h1);
    step(999);
    check("m4_no_timeout_yet", 16'({timeout, busy}), 16'h1);
    step(1);
    check("m4_timeout", 16'({timeout, busy, squ_r0}), 16'h4);
    step(1);
    check("m4_timeout_one_cycle", 16'({timeout, busy}), 16'h0);

    // async reset mid-WAIT1
    squ_in0 = 1'b0;
    squ_in1 = 1'b0;
    step(10);
    arm_pulse();
    squ_in0 = 1'b1;
    step(8);
    check("m5_pre_reset_r0", 16'({squ_r0, filt0}), 16'h3);
    rst = 1'b1;
    #2;
    check("m5_async_reset", outs(), 16'h0);
    step(1);
    rst = 1'b0;
    step(3);
    check("m5_post_reset_busy", 16'(busy), 16'h0);

    // timeout disabled on the second instance
    squ_in0 = 1'b0;
    step(10);
    arm2 = 1'b1;
    step(1);
    arm2 = 1'b0;
    check("t0_busy_armed", 16'(busy_2), 16'h1);
    step(5000);
    check("t0_busy_after_5000", 16'(busy_2), 16'h1);
    check("t0_no_timeout", 16'(n_to2), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/squ_cond_gate.md
Name: squ_cond_gate

Overview:
- Upstream conditioning stage for time_measure.
- Takes two raw asynchronous square inputs and synchronises them into clk.
- Glitch-filters each channel.
- Turns the first qualified rising edge on ch0, then the first on ch1, into the clean step levels squ_r0 / squ_r1 that the interval counter consumes.
- Adds per-measurement arming, a done flag and a timeout abort.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per channel; legal range 2..4.
- FILT_LEN, 4: consecutive equal synchronised samples needed to change the filtered level; legal range 1..255.
- TIMEOUT_CYC, 100000000: clk cycles allowed from arm to done; 0 disables the timeout.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse that starts or restarts a measurement.
- squ_in0  in  1  raw start-event square input, asynchronous.
- squ_in1  in  1  raw stop-event square input, asynchronous.
- squ_r0  out  1  start step to time_measure.
- squ_r1  out  1  stop step to time_measure.
- filt0  out  1  filtered level of ch0.
- filt1  out  1  filtered level of ch1.
- busy  out  1  high while in WAIT0 or WAIT1.
- done  out  1  one-cycle pulse when squ_r1 is set.
- timeout  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - All sync flops, filter counters, filt0/1, edge-delay flops, timer, squ_r0/1, busy, done and timeout are 0.
  - FSM state is IDLE.
  - Reset asserted mid-operation forces these values immediately, with no clock required.
- Synchroniser: SYNC_STAGES-deep flop chain per channel; sN is the last stage.
- Glitch filter, per channel:
  - 8-bit counter fc; registered level filt.
  - If sN == filt: fc <= 0.
  - Else if fc == FILT_LEN-1: filt <= sN, fc <= 0.
  - Else: fc <= fc+1.
  - filt therefore changes on the FILT_LEN-th consecutive differing sample.
  - Pulses shorter than FILT_LEN cycles never pass.
- Edge detect: riseK = filtK & ~filtK_d, where filtK_d is filtK delayed one cycle.
- Latency: squ_rK rises exactly SYNC_STAGES+FILT_LEN+1 clk edges after the first edge that samples squ_inK high. This is 7 with defaults, and identical for both channels, so the interval is preserved cycle-exact.
- FSM states and transitions:
  - IDLE: squ_r0 = squ_r1 = 0, busy = 0. On arm: go to WAIT0, timer <= 0.
  - WAIT0: rise1 is ignored. On rise0: squ_r0 <= 1, go to WAIT1. A rise1 in the same cycle as rise0 is ignored; a later ch1 edge is required.
  - WAIT1: On rise1: squ_r1 <= 1, done <= 1 for one cycle, go to HOLD. Further rise0 events are ignored.
  - HOLD: squ_r0 = squ_r1 = 1 held, busy = 0. On arm: squ_r0 and squ_r1 cleared on that edge, go to WAIT0.
- Timer:
  - 32-bit; increments each cycle in WAIT0 and WAIT1.
  - When TIMEOUT_CYC != 0 and timer == TIMEOUT_CYC-1, the next edge does all of: timeout <= 1 (one cycle), squ_r0 <= 0, squ_r1 <= 0, go to IDLE.
  - The timeout takes priority over a rise event in the same cycle.
- arm while busy: restart. Clear squ_r0, squ_r1 and timer, go to WAIT0.
  - arm in the same cycle as rise1 or the timeout also restarts; done and timeout are suppressed.
- The filters run continuously in every state; filt0/filt1 are valid outside a measurement.
- busy = (state == WAIT0) | (state == WAIT1), driven from a register.

Optional Feature:
- Macro: SQU_GLITCH_CNT_EN.
- Defined:
  - Adds ports glitch_cnt0 and glitch_cnt1, each out, 16 bits.
  - glitch_cntK increments, saturating at 16'hFFFF, whenever sN returns equal to filt while fc != 0 (an aborted run).
  - Cleared on rst and on arm.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst = 1 for 100 ns with inputs toggling -> every output 0; after release, busy stays 0 and the state is IDLE.
- Clean measurement, defaults:
  - Stimulus: arm at cycle 10, squ_in0 rises at cycle 60, squ_in1 rises at cycle 210.
  - Expect: squ_r0 high from cycle 67, squ_r1 high from cycle 217, done pulse on the squ_r1 rising edge, busy 1 over cycles 11..216, outputs held high afterwards.
- Glitch rejection, FILT_LEN = 4: 3-cycle high pulses on squ_in0 while in WAIT0 -> filt0 and squ_r0 stay 0; a 4-cycle pulse sets squ_r0.
  - With SQU_GLITCH_CNT_EN: glitch_cnt0 equals the number of 3-cycle pulses.
- Ordering:
  - ch1 edge before ch0: ignored; squ_r1 is set only by a ch1 edge after squ_r0.
  - Simultaneous ch0/ch1 edges: only squ_r0 is set, state WAIT1.
- Timeout, TIMEOUT_CYC = 1000: arm at cycle 0 and no edges -> timeout pulse in cycle 1000, busy falls, state IDLE, squ_r0 = 0.
  - TIMEOUT_CYC = 0 -> no timeout after 5000 cycles.
- Re-arm and reset mid-operation:
  - arm in WAIT1 -> squ_r0 drops next edge, state WAIT0, timer restarted.
  - rst pulse mid-WAIT1 -> outputs 0 immediately.
  - Re-arm in HOLD -> a new measurement completes correctly.
